// File: rtl/alu_mul_seq.sv
// Purpose : unsigned shift-and-add multiplier that borrows the shared 32-bit ALU for its adds.
// Latency : k+1 cycles from accept to done (k = index of highest set multiplier bit + 1), 1 when multiplier is 0.
// Backpressure: start is taken only while ready; busy holds the ALU mux and stalls the datapath.
//
// Ports:
//   clk, rst               - clock and synchronous active-high reset
//   start / ready          - request handshake, accepted when both high
//   busy                   - this block owns the ALU input mux
//   multiplicand/multiplier- operands, sampled on the accept edge only
//   product / done         - registered low WIDTH bits of the product, done pulses once
//   alu_a/alu_b/alu_ctrl   - drive the shared ALU inputs
//   alu_y                  - ALU result, trusted only while alu_ctrl is ADD
module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             done,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_y
);

  // ALU operation codes shared with the ALU decoder.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_OFF = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   acc, acc_d;
  logic [WIDTH-1:0]   mc, mc_d;
  logic [WIDTH-1:0]   mp, mp_d;
  logic [CNT_W-1:0]   cnt, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mc      <= '0;
      mp      <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      acc <= acc_d;
      mc  <= mc_d;
      mp  <= mp_d;
      cnt <= cnt_d;
      // Load on the edge entering DONE so product is valid alongside the done pulse.
      if (state != DONE && state_d == DONE) begin
        product <= acc_d;
      end
    end
  end

  always_comb begin
    state_d  = state;
    acc_d    = acc;
    mc_d     = mc;
    mp_d     = mp;
    cnt_d    = cnt;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_OFF;
    done     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          mc_d    = multiplicand;
          mp_d    = multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (multiplier == '0) ? DONE : ITER;
        end
      end

      ITER: begin
        // The ALU floats its output when OFF, so acc only follows alu_y on an ADD.
        if (mp[0]) begin
          alu_ctrl = ALU_ADD;
          alu_a    = acc;
          alu_b    = mc;
          acc_d    = alu_y;
        end
        mc_d  = mc << 1;
        mp_d  = mp >> 1;
        cnt_d = cnt + 1'b1;
        // Stop as soon as no set multiplier bits remain; the count bound is a backstop.
        if (mp_d == '0 || cnt == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_alu_mul_seq.sv
// Purpose : directed self-checking bench for alu_mul_seq with a behavioural ALU.
// Latency : checks done/product timing against hand-computed cycle counts.
// Backpressure: exercises ignored start while busy and back-to-back accepts with start held.
module tb_alu_mul_seq;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_OFF = 3'b000;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ready;
  logic        busy;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] product;
  logic        done;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_y;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_p;

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ready        (ready),
    .busy         (busy),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_y        (alu_y)
  );

  // Behavioural ALU: a poison value stands in for the floating output under OFF.
  assign alu_y = (alu_ctrl == ALU_ADD) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation: exp_k = ITER cycles, exp_adds = cycles with ADD.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_p,
                       input int exp_k, input int exp_adds, input bit mid_start);
    int done_cyc;
    int adds;
    int bad;
    logic [2:0] exp_ctrl;
    done_cyc = 0;
    adds     = 0;
    bad      = 0;
    @(negedge clk);
    check("ready_before", {31'd0, ready}, 32'd1);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      exp_ctrl = (cyc <= exp_k && b[cyc-1]) ? ALU_ADD : ALU_OFF;
      if (alu_ctrl == ALU_ADD) adds++;
      if (alu_ctrl !== exp_ctrl) bad++;
      if (busy !== 1'b1 || ready !== 1'b0) bad++;
      if (product !== prev_p) bad++;
      // Stray request mid-run must be ignored.
      start = mid_start && (cyc == 2);
      if (start) begin
        multiplicand = 32'd1;
        multiplier   = 32'd1;
      end
    end
    start = 1'b0;
    check("done_cycle", done_cyc, exp_k + 1);
    check("product", product, exp_p);
    check("iter_bad", bad, 0);
    check("add_cycles", adds, exp_adds);
    @(negedge clk);
    check("ready_after", {31'd0, ready}, 32'd1);
    check("done_pulse_once", {31'd0, done}, 32'd0);
    check("product_held", product, exp_p);
    prev_p = exp_p;
  endtask

  initial begin
    int done_n1, done_n2, rdy_between;
    logic [31:0] p1, p2;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    prev_p       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_product", product, 32'd0);
    check("rst_ctrl", {29'd0, alu_ctrl}, {29'd0, ALU_OFF});
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);

    do_op(32'd3, 32'd5, 32'd15, 3, 2, 1'b0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32, 32, 1'b0);
    do_op(32'h1234_5678, 32'd0, 32'd0, 0, 0, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 3, 2, 1'b1);

    // Reset on ITER cycle 10 of a long run.
    @(negedge clk);
    multiplicand = 32'd100;
    multiplier   = 32'h8000_0000;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_product", product, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ctrl", {29'd0, alu_ctrl}, {29'd0, ALU_OFF});
    prev_p = '0;
    do_op(32'd2, 32'd3, 32'd6, 2, 2, 1'b0);

    // Back-to-back with start held: 7*9 then 0x10000*0x10000.
    done_n1     = 0;
    done_n2     = 0;
    rdy_between = 0;
    p1          = '1;
    p2          = '1;
    @(negedge clk);
    multiplicand = 32'd7;
    multiplier   = 32'd9;
    start        = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        multiplicand = 32'h0001_0000;
        multiplier   = 32'h0001_0000;
      end
      if (done && done_n1 == 0) begin
        done_n1 = n;
        p1      = product;
      end else if (done) begin
        done_n2 = n;
        p2      = product;
        start   = 1'b0;
        break;
      end else if (ready && done_n1 != 0) begin
        rdy_between++;
      end
    end
    start = 1'b0;
    check("b2b_done1", done_n1, 5);
    check("b2b_prod1", p1, 32'd63);
    check("b2b_done2", done_n2, 24);
    check("b2b_prod2", p2, 32'd0);
    check("b2b_ready_gap", rdy_between, 1);
    @(negedge clk);
    check("b2b_idle", {31'd0, ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
